// File: rtl/golden_nonce_unit_pkg.sv
// golden_nonce_unit_pkg: shared types and constants for the golden nonce unit.
package golden_nonce_unit_pkg;

    typedef logic [31:0] nonce_t;

    // Pre-add H7 value; final H7 is zero once 0x5be0cd19 is added.
    localparam nonce_t GOLDEN_H7   = 32'ha41f32e7;
    localparam int     PIPE130_LAT = 130;
    localparam int     PIPE123_LAT = 123;
    localparam int     DEF_LATENCY = PIPE130_LAT + PIPE123_LAT;

endpackage

// File: rtl/golden_nonce_unit_if.sv
// golden_nonce_unit_if: nonce issue, hash return and host hit-queue signals.
// GOLDEN_NONCE_STATS_EN adds the tap/hit statistics outputs.
interface golden_nonce_unit_if;
    import golden_nonce_unit_pkg::*;

    logic   run;
    logic   new_work;
    nonce_t nonce_start;
    nonce_t nonce;
    logic   nonce_valid;
    nonce_t hash_in;
    logic   golden_valid;
    nonce_t golden_nonce;
    logic   golden_ack;
    logic   overflow;
    logic   wrapped;
`ifdef GOLDEN_NONCE_STATS_EN
    logic [31:0] hash_count;
    logic [15:0] hit_count;

    modport slave (
        input  run, new_work, nonce_start, hash_in, golden_ack,
        output nonce, nonce_valid, golden_valid, golden_nonce, overflow, wrapped,
        output hash_count, hit_count
    );

    modport master (
        output run, new_work, nonce_start, hash_in, golden_ack,
        input  nonce, nonce_valid, golden_valid, golden_nonce, overflow, wrapped,
        input  hash_count, hit_count
    );
`else
    modport slave (
        input  run, new_work, nonce_start, hash_in, golden_ack,
        output nonce, nonce_valid, golden_valid, golden_nonce, overflow, wrapped
    );

    modport master (
        output run, new_work, nonce_start, hash_in, golden_ack,
        input  nonce, nonce_valid, golden_valid, golden_nonce, overflow, wrapped
    );
`endif

endinterface

// File: rtl/golden_nonce_unit_golden_fifo.sv
// golden_fifo: DEPTH x 32 hit queue with a flop-held head and a drop strobe
// for pushes refused while full.
module golden_fifo
    import golden_nonce_unit_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic   clk,
    input  logic   reset_n,
    input  logic   i_push,
    input  nonce_t i_data,
    input  logic   i_pop,
    output logic   o_valid,
    output nonce_t o_head,
    output logic   o_ovf
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

    nonce_t        r_mem [DEPTH];
    logic [AW-1:0] r_rd;
    logic [AW-1:0] r_wr;
    logic [AW:0]   r_cnt;
    logic          w_full;
    logic          w_empty;
    logic          w_pop;
    logic          w_push;

    assign w_full  = r_cnt == FULL_CNT;
    assign w_empty = r_cnt == '0;
    assign w_pop   = i_pop && !w_empty;
    // A pop frees the slot in the same cycle, so a push when full is still taken.
    assign w_push  = i_push && (!w_full || w_pop);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
            r_rd  <= '0;
            r_wr  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr] <= i_data;
                r_wr        <= r_wr + 1'b1;
            end
            if (w_pop) r_rd <= r_rd + 1'b1;
            r_cnt <= r_cnt + {{AW{1'b0}}, w_push} - {{AW{1'b0}}, w_pop};
        end
    end

    assign o_valid = !w_empty;
    assign o_head  = r_mem[r_rd];
    assign o_ovf   = i_push && w_full && !w_pop;

endmodule

// File: rtl/golden_nonce_unit.sv
// golden_nonce_unit: issues nonces, matches returning hash words against GOLDEN
// and queues hit nonces for the host. GOLDEN_NONCE_STATS_EN adds tap/hit counters.
module golden_nonce_unit
    import golden_nonce_unit_pkg::*;
#(
    parameter int     LATENCY    = DEF_LATENCY,
    parameter int     FIFO_DEPTH = 4,
    parameter nonce_t GOLDEN     = GOLDEN_H7
) (
    input logic                clk,
    input logic                reset_n,
    golden_nonce_unit_if.slave bus
);

    nonce_t             r_nonce;
    nonce_t             r_trail;
    logic               r_valid;
    logic               r_ovf;
    logic               r_wrap;
    logic [LATENCY-1:0] r_dl;
    logic               w_tap;
    logic               w_hit;
    logic               w_ovf;

    assign w_tap = r_dl[LATENCY-1];
    assign w_hit = w_tap && (bus.hash_in == GOLDEN);

    // The nonce advances after each cycle it was presented valid, so the
    // trailing counter only needs to count taps to recover it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_nonce <= '0;
            r_trail <= '0;
            r_valid <= 1'b0;
            r_ovf   <= 1'b0;
            r_wrap  <= 1'b0;
            r_dl    <= '0;
        end else begin
            r_valid <= bus.run;
            r_ovf   <= (r_ovf && !bus.new_work) || w_ovf;
            if (bus.new_work) begin
                r_nonce <= bus.nonce_start;
                r_trail <= bus.nonce_start;
                r_dl    <= '0;
                r_wrap  <= 1'b0;
            end else begin
                r_dl <= {r_dl[LATENCY-2:0], r_valid};
                if (r_valid) begin
                    r_nonce <= r_nonce + 32'd1;
                    if (&r_nonce) r_wrap <= 1'b1;
                end
                if (w_tap) r_trail <= r_trail + 32'd1;
            end
        end
    end

    golden_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .i_push  (w_hit),
        .i_data  (r_trail),
        .i_pop   (bus.golden_ack),
        .o_valid (bus.golden_valid),
        .o_head  (bus.golden_nonce),
        .o_ovf   (w_ovf)
    );

    assign bus.nonce       = r_nonce;
    assign bus.nonce_valid = r_valid;
    assign bus.overflow    = r_ovf;
    assign bus.wrapped     = r_wrap;

`ifdef GOLDEN_NONCE_STATS_EN
    logic [31:0] r_hash_cnt;
    logic [15:0] r_hit_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_hash_cnt <= '0;
            r_hit_cnt  <= '0;
        end else begin
            if (w_tap && !(&r_hash_cnt)) r_hash_cnt <= r_hash_cnt + 32'd1;
            if (w_hit && !(&r_hit_cnt))  r_hit_cnt  <= r_hit_cnt + 16'd1;
        end
    end

    assign bus.hash_count = r_hash_cnt;
    assign bus.hit_count  = r_hit_cnt;
`endif

endmodule

// File: tb/tb_golden_nonce_unit.sv
// tb_golden_nonce_unit: table vectors, directed corner sequences and random
// traffic checked against a queue-based reference model.
module tb_golden_nonce_unit;

    localparam int          L     = 253;
    localparam int          DEPTH = 4;
    localparam logic [31:0] G     = 32'ha41f32e7;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    golden_nonce_unit_if bus();

    golden_nonce_unit dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    typedef struct {
        int          t;
        logic [31:0] n;
    } pend_t;

    typedef struct {
        logic        run;
        logic        nw;
        logic [31:0] start;
        logic [31:0] e_nonce;
        logic        e_valid;
        logic        e_wrap;
    } vec_t;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc     = 0;
    pend_t       pend[$];
    logic [31:0] fq[$];
    logic [31:0] m_nonce;
    logic        m_valid;
    logic        m_ovf;
    logic        m_wrap;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        pend.delete();
        fq.delete();
        m_nonce = '0;
        m_valid = 1'b0;
        m_ovf   = 1'b0;
        m_wrap  = 1'b0;
    endtask

    // Each presented valid nonce is scheduled to meet its hash word L edges later.
    task automatic model_edge();
        logic        hit;
        logic        ovf_ev;
        logic [31:0] hn;
        pend_t       p;
        hit    = 1'b0;
        ovf_ev = 1'b0;
        hn     = '0;
        if (pend.size() > 0 && pend[0].t == cyc + 1) begin
            hn  = pend[0].n;
            hit = (bus.hash_in == G);
            void'(pend.pop_front());
        end
        if (bus.golden_ack && fq.size() > 0) void'(fq.pop_front());
        if (hit) begin
            if (fq.size() < DEPTH) fq.push_back(hn);
            else ovf_ev = 1'b1;
        end
        if (bus.new_work) begin
            pend.delete();
            m_nonce = bus.nonce_start;
            m_wrap  = 1'b0;
            m_ovf   = ovf_ev;
        end else begin
            if (m_valid) begin
                p.t = cyc + 1 + L;
                p.n = m_nonce;
                pend.push_back(p);
                if (m_nonce == 32'hffffffff) m_wrap = 1'b1;
                m_nonce = m_nonce + 32'd1;
            end
            if (ovf_ev) m_ovf = 1'b1;
        end
        m_valid = bus.run;
    endtask

    task automatic check_model();
        chk("nonce", bus.nonce, m_nonce);
        chk("nonce_valid", 32'(bus.nonce_valid), 32'(m_valid));
        chk("golden_valid", 32'(bus.golden_valid), 32'(fq.size() > 0));
        if (fq.size() > 0) chk("golden_nonce", bus.golden_nonce, fq[0]);
        chk("overflow", 32'(bus.overflow), 32'(m_ovf));
        chk("wrapped", 32'(bus.wrapped), 32'(m_wrap));
    endtask

    task automatic step();
        if (reset_n) model_edge();
        else model_reset();
        @(posedge clk);
        #1;
        cyc++;
        check_model();
    endtask

    task automatic run_to(input int target);
        while (cyc < target) step();
    endtask

    task automatic pop_expect(input string name, input logic [31:0] exp);
        chk({name, "_valid"}, 32'(bus.golden_valid), 32'd1);
        chk({name, "_head"}, bus.golden_nonce, exp);
        bus.golden_ack = 1'b1;
        step();
        bus.golden_ack = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout, expected $finish");
        $fatal(1);
    end

    initial begin
        vec_t        tv[11];
        logic [31:0] dexp[4];
        int          e0;

        bus.run         = 1'b0;
        bus.new_work    = 1'b0;
        bus.nonce_start = '0;
        bus.hash_in     = '0;
        bus.golden_ack  = 1'b0;
        model_reset();

        tv[0]  = '{1'b1, 1'b1, 32'hfffffffe, 32'hfffffffe, 1'b1, 1'b0};
        tv[1]  = '{1'b1, 1'b0, 32'h0,        32'hffffffff, 1'b1, 1'b0};
        tv[2]  = '{1'b1, 1'b0, 32'h0,        32'h00000000, 1'b1, 1'b1};
        tv[3]  = '{1'b0, 1'b0, 32'h0,        32'h00000001, 1'b0, 1'b1};
        tv[4]  = '{1'b0, 1'b0, 32'h0,        32'h00000001, 1'b0, 1'b1};
        tv[5]  = '{1'b0, 1'b1, 32'h10,       32'h00000010, 1'b0, 1'b0};
        tv[6]  = '{1'b1, 1'b0, 32'h0,        32'h00000010, 1'b1, 1'b0};
        tv[7]  = '{1'b0, 1'b0, 32'h0,        32'h00000011, 1'b0, 1'b0};
        tv[8]  = '{1'b1, 1'b0, 32'h0,        32'h00000011, 1'b1, 1'b0};
        tv[9]  = '{1'b1, 1'b1, 32'h20,       32'h00000020, 1'b1, 1'b0};
        tv[10] = '{1'b1, 1'b0, 32'h0,        32'h00000021, 1'b1, 1'b0};

        step();
        step();
        chk("rst_golden_nonce", bus.golden_nonce, 32'h0);
        reset_n = 1'b1;
        step();

        for (int i = 0; i < 11; i++) begin
            bus.run         = tv[i].run;
            bus.new_work    = tv[i].nw;
            bus.nonce_start = tv[i].start;
            step();
            chk("tbl_nonce", bus.nonce, tv[i].e_nonce);
            chk("tbl_valid", 32'(bus.nonce_valid), 32'(tv[i].e_valid));
            chk("tbl_wrapped", 32'(bus.wrapped), 32'(tv[i].e_wrap));
        end
        bus.new_work = 1'b0;

        // Single hit on nonce 0x1005 with run held high.
        bus.run = 1'b1; bus.new_work = 1'b1; bus.nonce_start = 32'h1000;
        step();
        bus.new_work = 1'b0;
        e0 = cyc;
        run_to(e0 + 5);
        chk("A_issue", bus.nonce, 32'h1005);
        run_to(e0 + 5 + L);
        chk("A_pre_valid", 32'(bus.golden_valid), 32'd0);
        bus.hash_in = G;
        step();
        bus.hash_in = '0;
        bus.run = 1'b0;
        pop_expect("A", 32'h1005);
        chk("A_post_valid", 32'(bus.golden_valid), 32'd0);

        // run toggled 1,0,1,0: GOLDEN on a gap is ignored, third tap reports start+2.
        bus.run = 1'b1; bus.new_work = 1'b1; bus.nonce_start = 32'h2000;
        step();
        bus.new_work = 1'b0;
        e0 = cyc;
        bus.run = 1'b0; step();
        bus.run = 1'b1; step();
        bus.run = 1'b0; step();
        bus.run = 1'b1; step();
        bus.run = 1'b0;
        run_to(e0 + 1 + L);
        bus.hash_in = G;
        step();
        bus.hash_in = '0;
        chk("B_gap", 32'(bus.golden_valid), 32'd0);
        run_to(e0 + 4 + L);
        bus.hash_in = G;
        step();
        bus.hash_in = '0;
        pop_expect("B", 32'h2002);

        // Five hits into a depth-4 queue, then ack together with a sixth hit.
        bus.run = 1'b1; bus.new_work = 1'b1; bus.nonce_start = 32'h7000;
        step();
        bus.new_work = 1'b0;
        e0 = cyc;
        repeat (5) step();
        bus.run = 1'b0;
        run_to(e0 + L);
        bus.hash_in = G;
        run_to(e0 + 5 + L);
        chk("D_full_head", bus.golden_nonce, 32'h7000);
        chk("D_overflow", 32'(bus.overflow), 32'd1);
        bus.golden_ack = 1'b1;
        step();
        bus.golden_ack = 1'b0;
        bus.hash_in = '0;
        chk("D_overflow_kept", 32'(bus.overflow), 32'd1);
        dexp = '{32'h7001, 32'h7002, 32'h7003, 32'h7005};
        for (int k = 0; k < 4; k++) pop_expect("D_pop", dexp[k]);
        chk("D_empty", 32'(bus.golden_valid), 32'd0);
        bus.golden_ack = 1'b1;
        step();
        bus.golden_ack = 1'b0;
        chk("D_ack_empty", 32'(bus.golden_valid), 32'd0);

        // New work mid-flight with GOLDEN forced: only the new stream reports.
        bus.run = 1'b1; bus.new_work = 1'b1; bus.nonce_start = 32'h100;
        step();
        bus.new_work = 1'b0;
        e0 = cyc;
        run_to(e0 + 255);
        chk("C_last_old", bus.nonce, 32'h1ff);
        bus.new_work = 1'b1; bus.nonce_start = 32'h5000;
        step();
        bus.new_work = 1'b0;
        bus.hash_in = G;
        repeat (300) step();
        bus.hash_in = '0;
        bus.run = 1'b0;
        step();
        chk("C_overflow", 32'(bus.overflow), 32'd1);
        for (int k = 0; k < 4; k++) pop_expect("C_pop", 32'h5000 + 32'(k));
        chk("C_empty", 32'(bus.golden_valid), 32'd0);

        // Asynchronous reset mid-run with two queued hits.
        bus.run = 1'b1; bus.new_work = 1'b1; bus.nonce_start = 32'h9000;
        step();
        bus.new_work = 1'b0;
        e0 = cyc;
        run_to(e0 + L);
        bus.hash_in = G;
        step();
        step();
        bus.hash_in = '0;
        chk("F_two_head", bus.golden_nonce, 32'h9000);
        reset_n = 1'b0;
        #1;
        model_reset();
        chk("rst_nonce", bus.nonce, 32'h0);
        chk("rst_nonce_valid", 32'(bus.nonce_valid), 32'd0);
        chk("rst_golden_valid", 32'(bus.golden_valid), 32'd0);
        chk("rst_head", bus.golden_nonce, 32'h0);
        chk("rst_overflow", 32'(bus.overflow), 32'd0);
        chk("rst_wrapped", 32'(bus.wrapped), 32'd0);
        step();
        step();
        reset_n = 1'b1;
        bus.run = 1'b0;
        bus.hash_in = G;
        repeat (300) step();
        chk("F_no_stale", 32'(bus.golden_valid), 32'd0);
        bus.hash_in = '0;
        bus.run = 1'b1; bus.new_work = 1'b1; bus.nonce_start = 32'ha000;
        step();
        bus.new_work = 1'b0;
        bus.run = 1'b0;
        e0 = cyc;
        run_to(e0 + L);
        bus.hash_in = G;
        step();
        bus.hash_in = '0;
        pop_expect("F", 32'ha000);

        // Random traffic against the reference model.
        bus.new_work = 1'b1; bus.nonce_start = $urandom;
        for (int i = 0; i < 3000; i++) begin
            bus.run         = $urandom_range(0, 9) < 7;
            bus.hash_in     = ($urandom_range(0, 2) == 0) ? G : $urandom;
            bus.golden_ack  = $urandom_range(0, 3) == 0;
            step();
            bus.new_work    = $urandom_range(0, 299) == 0;
            bus.nonce_start = ($urandom_range(0, 3) == 0) ?
                              32'hfffffff0 + 32'($urandom_range(0, 15)) : $urandom;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
